// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a small 4-bit ALU with a registered, handshaked result.
// Define ALU_ARB_OPCOUNT_EN to add the op_count port and its wrapping completed-operation counter.
module alu_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [1:0]       req,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  input  logic [3:0]       a0,
  input  logic [3:0]       b0,
  input  logic [3:0]       a1,
  input  logic [3:0]       b1,
  output logic [1:0]       gnt,
  output logic [7:0]       ALUOut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
`ifdef ALU_ARB_OPCOUNT_EN
  ,
  output logic [CNT_W-1:0] op_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state;
  logic       prio;
  logic       served;
  logic       pick;
  logic [2:0] capOp;
  logic [3:0] capA;
  logic [3:0] capB;
  logic [7:0] aluRes;

  // Both requesting: the priority pointer decides; otherwise the lone requester wins.
  always_comb begin
    pick = 1'b0;
    if (req == 2'b11) pick = prio;
    else              pick = req[1];
  end

  always_comb begin
    aluRes = 8'h00;
    case (capOp)
      3'b000:  aluRes = {3'b000, {1'b0, capA} + {1'b0, capB}};
      3'b001:  aluRes = {capA, ~capB};
      3'b010:  aluRes = {capA, capB};
      3'b011:  aluRes = {4'h0, capA & capB};
      3'b100:  aluRes = {4'h0, capA | capB};
      3'b101:  aluRes = {4'h0, capA ^ capB};
      3'b110:  aluRes = {~capA, ~capB};
      default: aluRes = 8'h00;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      prio      <= 1'b0;
      served    <= 1'b0;
      gnt       <= 2'b00;
      ALUOut    <= 8'h00;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      capOp     <= 3'b000;
      capA      <= 4'h0;
      capB      <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            served <= pick;
            capOp  <= pick ? op1 : op0;
            capA   <= pick ? a1 : a0;
            capB   <= pick ? b1 : b0;
            gnt    <= pick ? 2'b10 : 2'b01;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          gnt       <= 2'b00;
          ALUOut    <= aluRes;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          // The unserved requester gets priority for the next contention.
          if (out_ready) begin
            out_valid <= 1'b0;
            prio      <= ~served;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          gnt       <= 2'b00;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_OPCOUNT_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      op_count <= '0;
    end else if (state == HOLD && out_ready) begin
      op_count <= op_count + 1'b1;
    end
  end
`endif

endmodule
